// File: rtl/carpma_n.sv
// carpma_n: parametrised shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Optional macro CARPMA_SIGNED_EN adds two's-complement operation selected by signed_mode.
module carpma_n #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  input  logic             signed_mode,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     mcand_q;
  logic [W-1:0]     mq_q;
  logic [W:0]       acc_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   product_q;
  logic             busy_q;
  logic             done_q;

  logic [W:0]       add_d;
  logic [W:0]       acc_d;
  logic [W-1:0]     mq_d;
  logic [W-1:0]     a_d;
  logic [W-1:0]     b_d;
  logic [2*W-1:0]   prod_d;

`ifdef CARPMA_SIGNED_EN
  logic             neg_q;
  logic             neg_d;

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    if (v[W-1]) begin
      abs_w = ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      abs_w = v;
    end
  endfunction

  function automatic logic [2*W-1:0] negate_p(input logic [2*W-1:0] p);
    negate_p = ~p + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitudes are latched so the iteration datapath stays purely unsigned.
  always_comb begin
    a_d   = multiplicand;
    b_d   = multiplier;
    neg_d = 1'b0;
    if (signed_mode) begin
      a_d   = abs_w(multiplicand);
      b_d   = abs_w(multiplier);
      neg_d = multiplicand[W-1] ^ multiplier[W-1];
    end else begin
      a_d   = multiplicand;
      b_d   = multiplier;
      neg_d = 1'b0;
    end
  end
`else
  logic unused_signed_mode_s;
  assign unused_signed_mode_s = signed_mode;

  always_comb begin
    a_d = multiplicand;
    b_d = multiplier;
  end
`endif

  // One iteration: conditional add keeping the carry, then shift {acc,mq} right.
  always_comb begin
    add_d = acc_q;
    if (mq_q[0]) begin
      add_d = acc_q + {1'b0, mcand_q};
    end else begin
      add_d = acc_q;
    end
    acc_d  = {1'b0, add_d[W:1]};
    mq_d   = {add_d[0], mq_q[W-1:1]};
    prod_d = {acc_d[W-1:0], mq_d};
`ifdef CARPMA_SIGNED_EN
    if (neg_q) begin
      prod_d = negate_p({acc_d[W-1:0], mq_d});
    end else begin
      prod_d = {acc_d[W-1:0], mq_d};
    end
`endif
  end

  // Control FSM with registered handshake outputs and the iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= {W{1'b0}};
      mq_q      <= {W{1'b0}};
      acc_q     <= {(W+1){1'b0}};
      cnt_q     <= {CW{1'b0}};
      product_q <= {(2*W){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CARPMA_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= a_d;
            mq_q    <= b_d;
            acc_q   <= {(W+1){1'b0}};
            cnt_q   <= CW'(W);
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef CARPMA_SIGNED_EN
            neg_q   <= neg_d;
`endif
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            product_q <= prod_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            done_q    <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_carpma_n.sv
// Scoreboard bench for carpma_n: a W=4 and a W=8 instance sharing clock and reset.
module tb_carpma_n;

`ifdef CARPMA_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start4, sm4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        busy4, done4;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        busy8, done8;

  exp_t        q4[$];
  exp_t        q8[$];
  logic [63:0] held4, held8;
  logic        prev_done4, prev_done8;
  int          cyc;
  int          checks;
  int          failures;

  carpma_n #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .multiplicand(a4), .multiplier(b4),
    .signed_mode(sm4), .product(product4), .busy(busy4), .done(done4)
  );

  carpma_n #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .multiplicand(a8), .multiplier(b8),
    .signed_mode(sm8), .product(product8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    logic signed [7:0] sa, sb;
    if (SEN && sm) begin
      sa = {{4{a[3]}}, a};
      sb = {{4{b[3]}}, b};
      model4 = sa * sb;
    end else begin
      model4 = {4'd0, a} * {4'd0, b};
    end
  endfunction

  // W=4 output monitor: result, latency, pulse width, and hold between operations.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done4) check_eq("pulse4", {62'd0, done4, busy4}, 64'd0);
      if (done4) begin
        if (q4.size() == 0) begin
          check_eq("spurious_done4", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check_eq("prod4", {56'd0, product4}, e.val);
          check_eq("lat4", 64'(cyc), 64'(e.cyc));
          check_eq("busy_at_done4", {63'd0, busy4}, 64'd1);
          held4 = e.val;
        end
      end else begin
        check_eq("hold4", {56'd0, product4}, held4);
      end
      prev_done4 = done4;
    end
  end

  // W=8 output monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done8) check_eq("pulse8", {62'd0, done8, busy8}, 64'd0);
      if (done8) begin
        if (q8.size() == 0) begin
          check_eq("spurious_done8", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check_eq("prod8", {48'd0, product8}, e.val);
          check_eq("lat8", 64'(cyc), 64'(e.cyc));
          held8 = e.val;
        end
      end else begin
        check_eq("hold8", {48'd0, product8}, held8);
      end
      prev_done8 = done8;
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (busy4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy4) check_eq("idle_wait4", 64'd1, 64'd0);
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    e.val = {56'd0, model4(a, b, sm)};
    e.cyc = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0 || q8.size() != 0) begin
      check_eq("drain_timeout", 64'(q4.size() + q8.size()), 64'd0);
      q4.delete();
      q8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    checks = 0; failures = 0; cyc = 0;
    held4 = 64'd0; held8 = 64'd0;
    prev_done4 = 1'b0; prev_done8 = 1'b0;
    rst = 1'b1;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; sm4 = 1'b0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; sm8 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_product4", {56'd0, product4}, 64'd0);
    check_eq("rst_busy_done4", {62'd0, busy4, done4}, 64'd0);
    check_eq("rst_busy_done8", {62'd0, busy8, done8}, 64'd0);
    rst = 1'b0;

    op4(4'b1011, 4'b1110, 1'b0);
    drain(40);
    op4(4'd0, 4'd15, 1'b0);
    drain(40);
    op4(4'd15, 4'd15, 1'b0);
    drain(40);
    op4(4'd1, 4'd9, 1'b0);
    drain(40);

    // W=8 with start held high: two back-to-back operations W+2 cycles apart.
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    e.val = 64'd65025; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    a8 = 8'd16; b8 = 8'd3;
    e.val = 64'd48; e.cyc = cyc + 10 + 8;
    q8.push_back(e);
    repeat (10) @(negedge clk);
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    drain(60);

    // Reset two cycles into CALC aborts the operation with no done.
    op4(4'd11, 4'd13, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_product4", {56'd0, product4}, 64'd0);
    check_eq("async_rst_busy4", {63'd0, busy4}, 64'd0);
    q4.delete();
    held4 = 64'd0; held8 = 64'd0;
    prev_done4 = 1'b0; prev_done8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    op4(4'd7, 4'd6, 1'b0);
    drain(40);

    op4(4'h8, 4'h8, 1'b1);
    drain(40);
    op4(4'hD, 4'd5, 1'b1);
    drain(40);
    op4(4'd7, 4'hF, 1'b1);
    drain(40);
    op4(4'hD, 4'd5, 1'b0);
    drain(40);

    for (int i = 0; i < 6; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom));
      drain(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
